// File: rtl/mqoi_compose_ctrl.sv
// MQOI frame-composition sequencer: streams diff pixels, reads the old pixel,
// composes by diff alpha and writes back in place; tracks per-frame stats.
module mqoi_compose_ctrl #(
    parameter int NUM_PIXELS = 4096,
    parameter int ADDR_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_diff_valid,
    output logic              o_diff_ready,
    input  logic [31:0]       i_diff_rgba,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [31:0]       i_mem_rd_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [31:0]       o_mem_wr_data,
    output logic [ADDR_W:0]   o_changed_cnt,
    output logic [15:0]       o_frame_cnt,
    output logic              o_bad_alpha
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic              r_s1_vld;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [31:0]       r_s1_rgba;
    logic [ADDR_W:0]   r_changed_cnt;
    logic [15:0]       r_frame_cnt;
    logic              r_bad_alpha;

    logic w_accept;
    logic w_start_ok;
    logic w_ready;
    logic w_s1_keep;
    logic w_s1_bad;

    // A start landing on the done cycle is dropped, hence the r_done gate.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_accept    = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start_ok = i_start && !r_done;
                if (w_start_ok) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_ready  = 1'b1;
                w_accept = i_diff_valid;
                if (w_accept && (r_addr == LAST_ADDR)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_s1_keep = (r_s1_rgba[7:0] == 8'h00);
    assign w_s1_bad  = !w_s1_keep && (r_s1_rgba[7:0] != 8'hFF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_done        <= 1'b0;
            r_addr        <= '0;
            r_s1_vld      <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_rgba     <= '0;
            r_changed_cnt <= '0;
            r_frame_cnt   <= '0;
            r_bad_alpha   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= (r_state == ST_DRAIN);
            r_s1_vld <= w_accept;
            if (w_start_ok)    r_addr <= '0;
            else if (w_accept) r_addr <= r_addr + ADDR_W'(1);
            if (w_accept) begin
                r_s1_addr <= r_addr;
                r_s1_rgba <= i_diff_rgba;
            end
            if (r_state == ST_DRAIN) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_start_ok)                  r_changed_cnt <= '0;
            else if (r_s1_vld && !w_s1_keep) r_changed_cnt <= r_changed_cnt + (ADDR_W+1)'(1);
            if (w_start_ok)                 r_bad_alpha <= 1'b0;
            else if (r_s1_vld && w_s1_bad)  r_bad_alpha <= 1'b1;
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_diff_ready  = w_ready;
    assign o_mem_rd_en   = w_accept;
    assign o_mem_rd_addr = r_addr;
    assign o_mem_wr_en   = r_s1_vld;
    assign o_mem_wr_addr = r_s1_addr;
    // Old pixel arrives from the RAM in the stage-1 cycle; new colour forces opaque.
    assign o_mem_wr_data = !r_s1_vld ? 32'h0 :
                           w_s1_keep ? i_mem_rd_data : {r_s1_rgba[31:8], 8'hFF};
    assign o_changed_cnt = r_changed_cnt;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_bad_alpha   = r_bad_alpha;

endmodule

// File: tb/tb_mqoi_compose_ctrl.sv
// Bench for mqoi_compose_ctrl: 4-pixel frames against a frame-level image model.
module tb_mqoi_compose_ctrl;
    localparam int NP = 4;
    localparam int AW = 2;
    typedef logic [31:0] img_t [NP];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, diff_ready;
    logic          diff_valid = 1'b0;
    logic [31:0]   diff_rgba = 32'h0;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [31:0]   mem_rd_data = 32'h0;
    logic [31:0]   mem_wr_data;
    logic [AW:0]   changed_cnt;
    logic [15:0]   frame_cnt;
    logic          bad_alpha;

    mqoi_compose_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .i_diff_valid(diff_valid), .o_diff_ready(diff_ready), .i_diff_rgba(diff_rgba),
        .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data),
        .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
        .o_changed_cnt(changed_cnt), .o_frame_cnt(frame_cnt), .o_bad_alpha(bad_alpha)
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM: one-cycle read latency, preloadable between frames.
    logic [31:0] ram [NP];
    img_t        init_img;
    logic        load = 1'b0;
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NP; i++) ram[i] <= init_img[i];
        end else if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor
    logic [AW-1:0] wq_a [$];
    logic [31:0]   wq_d [$];
    logic [AW-1:0] rq_a [$];
    int acc_last = 0, done_n = 0, done_cyc = 0, spur_rd = 0;
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wq_a.push_back(mem_wr_addr);
            wq_d.push_back(mem_wr_data);
        end
        if (diff_valid && diff_ready) begin
            acc_last = cyc;
            if (mem_rd_en) rq_a.push_back(mem_rd_addr);
            else spur_rd++;
        end else if (mem_rd_en) spur_rd++;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    int checks = 0, failures = 0, frames_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"},     32'(busy), 32'h0);
        chk({pfx, "_done"},     32'(done), 32'h0);
        chk({pfx, "_ready"},    32'(diff_ready), 32'h0);
        chk({pfx, "_rd_en"},    32'(mem_rd_en), 32'h0);
        chk({pfx, "_wr_en"},    32'(mem_wr_en), 32'h0);
        chk({pfx, "_rd_addr"},  32'(mem_rd_addr), 32'h0);
        chk({pfx, "_wr_addr"},  32'(mem_wr_addr), 32'h0);
        chk({pfx, "_wr_data"},  mem_wr_data, 32'h0);
        chk({pfx, "_changed"},  32'(changed_cnt), 32'h0);
        chk({pfx, "_frames"},   32'(frame_cnt), 32'h0);
        chk({pfx, "_bad"},      32'(bad_alpha), 32'h0);
    endtask

    function automatic logic [31:0] rnd_diff();
        logic [7:0] a;
        case ($urandom_range(0, 3))
            1:       a = 8'hFF;
            2:       a = 8'($urandom);
            default: a = 8'h00;
        endcase
        return {24'($urandom), a};
    endfunction

    // Called at posedge+1; leaves the bench at posedge+1 of the cycle after start.
    task automatic load_and_start(input img_t img, output int s_cyc);
        init_img = img;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: toggling, 2: random
    task automatic run_frame(input string nm, input img_t img, input img_t dif, input int mode,
                             input bit start_in_run, input bit start_in_done, input bit exact);
        img_t expi;
        int ec = 0, idx = 0, guard = 0, s_cyc, wb, rb, db;
        bit eb = 0, v;
        for (int i = 0; i < NP; i++) begin
            if (dif[i][7:0] == 8'h00) expi[i] = img[i];
            else begin
                expi[i] = {dif[i][31:8], 8'hFF};
                ec++;
                if (dif[i][7:0] != 8'hFF) eb = 1;
            end
        end
        wb = wq_a.size(); rb = rq_a.size(); db = done_n;
        load_and_start(img, s_cyc);
        while (idx < NP && guard < 64) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            diff_valid = v;
            diff_rgba  = v ? dif[idx] : $urandom;
            start      = start_in_run && (guard == 1);
            @(negedge clk);
            if (guard == 0) begin
                chk({nm, "_busy_after_start"},  32'(busy), 32'h1);
                chk({nm, "_ready_after_start"}, 32'(diff_ready), 32'h1);
            end
            if (v && diff_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        diff_valid = 1'b0;
        start = 1'b0;
        chk({nm, "_accepts"}, idx, NP);
        @(negedge clk);
        chk({nm, "_drain_ready"}, 32'(diff_ready), 32'h0);
        chk({nm, "_drain_wr_en"}, 32'(mem_wr_en), 32'h1);
        chk({nm, "_drain_wr_addr"}, 32'(mem_wr_addr), NP - 1);
        chk({nm, "_drain_done"}, 32'(done), 32'h0);
        @(posedge clk); #1;
        start = start_in_done;
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'h1);
        chk({nm, "_done_busy"}, 32'(busy), 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        frames_exp++;
        chk({nm, "_idle_busy"}, 32'(busy), 32'h0);
        chk({nm, "_done_count"}, done_n - db, 1);
        chk({nm, "_done_latency"}, done_cyc - acc_last, 2);
        if (exact) chk({nm, "_frame_time"}, done_cyc - s_cyc + 1, NP + 3);
        chk({nm, "_wr_count"}, wq_a.size() - wb, NP);
        chk({nm, "_rd_count"}, rq_a.size() - rb, NP);
        for (int i = 0; i < NP; i++) begin
            if (wb + i < wq_a.size()) begin
                chk({nm, "_wr_addr"}, 32'(wq_a[wb + i]), i);
                chk({nm, "_wr_data"}, wq_d[wb + i], expi[i]);
            end
            if (rb + i < rq_a.size()) chk({nm, "_rd_addr"}, 32'(rq_a[rb + i]), i);
            chk({nm, "_ram"}, ram[i], expi[i]);
        end
        chk({nm, "_spurious_rd"}, spur_rd, 0);
        chk({nm, "_changed"}, 32'(changed_cnt), ec);
        chk({nm, "_bad_alpha"}, 32'(bad_alpha), 32'(eb));
        chk({nm, "_frame_cnt"}, 32'(frame_cnt), frames_exp);
    endtask

    initial begin
        img_t img, dif;
        int s_cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-transparent diffs: RAM unchanged
        for (int i = 0; i < NP; i++) begin
            img[i] = 32'h11223344;
            dif[i] = {24'($urandom), 8'h00};
        end
        run_frame("keep", img, dif, 0, 1'b0, 1'b0, 1'b1);

        // One opaque pixel at address 2
        for (int i = 0; i < NP; i++) begin
            img[i] = $urandom;
            dif[i] = {24'($urandom), 8'h00};
        end
        dif[2] = 32'hAABBCCFF;
        run_frame("px2", img, dif, 0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < NP; i++) begin
            img[i] = $urandom;
            dif[i] = rnd_diff();
        end
        run_frame("toggle", img, dif, 1, 1'b0, 1'b0, 1'b0);

        // Illegal alpha at pixel 1
        for (int i = 0; i < NP; i++) begin
            img[i] = $urandom;
            dif[i] = {24'($urandom), 8'h00};
        end
        dif[1] = 32'h55667780;
        run_frame("badalpha", img, dif, 0, 1'b0, 1'b0, 1'b1);

        // Stray starts in RUN and in the done cycle; bad_alpha cleared
        for (int i = 0; i < NP; i++) begin
            img[i] = $urandom;
            dif[i] = {24'($urandom), 8'h00};
        end
        dif[3] = {24'($urandom), 8'hFF};
        run_frame("stray_start", img, dif, 0, 1'b1, 1'b1, 1'b1);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NP; i++) begin
                img[i] = $urandom;
                dif[i] = rnd_diff();
            end
            run_frame("random", img, dif, 2, 1'b0, 1'b0, 1'b0);
        end

        // Reset after two accepts, then a clean frame from address 0
        for (int i = 0; i < NP; i++) begin
            img[i] = $urandom;
            dif[i] = {24'($urandom), 8'hFF};
        end
        load_and_start(img, s_cyc);
        diff_valid = 1'b1;
        diff_rgba  = dif[0];
        @(posedge clk); #1;
        diff_rgba  = dif[1];
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        diff_valid = 1'b0;
        frames_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NP; i++) begin
            img[i] = $urandom;
            dif[i] = rnd_diff();
        end
        run_frame("after_reset", img, dif, 0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
